// File: rtl/jk_seq_driver_if.sv
// Target-bit handshake plus JK drive/feedback and status bundle for jk_seq_driver.
// The master side (upstream + downstream flop) drives tgt_valid/tgt_bit/Q.
// The slave side (the driver) returns tgt_ready, J/K and the error status.
interface jk_seq_driver_if #(
    parameter int CNT_W = 8
);
    logic             tgt_valid;
    logic             tgt_bit;
    logic             tgt_ready;
    logic             Q;
    logic             J;
    logic             K;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output tgt_valid, tgt_bit, Q,
        input  tgt_ready, J, K, busy, err, err_cnt
    );

    modport slave (
        input  tgt_valid, tgt_bit, Q,
        output tgt_ready, J, K, busy, err, err_cnt
    );
endinterface

// File: rtl/jk_seq_driver.sv
// Purpose: queues target bits and drives a downstream JK flop to each one, then verifies Q.
// Latency: J/K one cycle after the push into an idle driver, err three cycles after; one bit per 2 cycles.
// Backpressure: tgt_ready = !full, no bypass. Optional macro JK_SEQ_TOGGLE_EN selects toggle excitation.
module jk_seq_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    jk_seq_driver_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head;

    logic             cur_tgt;
    logic [1:0]       jk_nxt;
    logic             chk;
    logic             j_q;
    logic             k_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Excitation needed to move the flop from q to t; {J,K}.
    function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JK_SEQ_TOGGLE_EN
        return (q != t) ? 2'b11 : 2'b00;
`else
        if (q == t) return 2'b00;
        return t ? 2'b10 : 2'b01;
`endif
    endfunction

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign push  = bus.tgt_valid && !full;
    assign head  = mem[rd_ptr];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; emptiness is the registered occupancy, so a bit pushed on a CHECK exit edge waits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = DRIVE;
            DRIVE:   state_nxt = CHECK;
            CHECK:   state_nxt = empty ? IDLE : DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop the head and compute its excitation when entering DRIVE; flag the CHECK exit.
    always_comb begin
        pop    = 1'b0;
        jk_nxt = 2'b00;
        chk    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    jk_nxt = excite(bus.Q, head);
                end
            end
            CHECK: begin
                chk = 1'b1;
                if (!empty) begin
                    pop    = 1'b1;
                    jk_nxt = excite(bus.Q, head);
                end
            end
            default: ;
        endcase
    end

    // FIFO storage; a push coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= bus.tgt_bit;
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered drive, current target, one-cycle err pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            cur_tgt   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            {j_q, k_q} <= jk_nxt;
            if (pop) cur_tgt <= head;
            err_q <= chk && (bus.Q != cur_tgt);
            if (chk && (bus.Q != cur_tgt) && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.tgt_ready = !full;
    assign bus.J         = j_q;
    assign bus.K         = k_q;
    assign bus.busy      = !empty || (state != IDLE);
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench for jk_seq_driver with a behavioural JK flop closing the Q loop.
// All actions happen 1 time unit after a rising edge; expected values are hand-derived.
module tb_jk_seq_driver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

`ifdef JK_SEQ_TOGGLE_EN
    localparam logic [1:0] P1 = 2'b11;  // drive to 1 from 0
    localparam logic [1:0] P0 = 2'b11;  // drive to 0 from 1
`else
    localparam logic [1:0] P1 = 2'b10;
    localparam logic [1:0] P0 = 2'b01;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q_model = 1'b0;
    logic q_stuck = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    jk_seq_driver_if #(.CNT_W(CNT_W)) bus ();

    jk_seq_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.Q = q_model;

    // Downstream JK flop model; q_stuck forces a broken flop holding 0.
    always @(posedge clk) begin
        if (rst || q_stuck) q_model <= 1'b0;
        else begin
            case ({bus.J, bus.K})
                2'b10:   q_model <= 1'b1;
                2'b01:   q_model <= 1'b0;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.tgt_valid = 1'b0;
        bus.tgt_bit   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_jk [10];
        logic       seq [4];
        int         pulses, wide, occ, accepted, acc, popd;
        logic       prev, saw_full;

        // Reset state
        do_reset();
        check("rst_jk",     {bus.J, bus.K}, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_err",    bus.err, 0);
        check("rst_errcnt", bus.err_cnt, 0);
        check("rst_ready",  bus.tgt_ready, 1);

        // Single bit into idle driver, then a push landing on the CHECK exit edge
        bus.tgt_valid = 1'b1; bus.tgt_bit = 1'b1;
        tick();                                     // e0: push
        bus.tgt_valid = 1'b0;
        check("t1_e0_jk",   {bus.J, bus.K}, 0);
        check("t1_e0_busy", bus.busy, 1);
        tick();                                     // e1: pop, drive
        check("t1_e1_jk",   {bus.J, bus.K}, P1);
        tick();                                     // e2: CHECK
        check("t1_e2_jk",   {bus.J, bus.K}, 0);
        check("t1_e2_q",    bus.Q, 1);
        bus.tgt_valid = 1'b1; bus.tgt_bit = 1'b0;
        tick();                                     // e3: exit CHECK, push not popped
        bus.tgt_valid = 1'b0;
        check("t1_nobypass_jk", {bus.J, bus.K}, 0);
        check("t1_e3_err",  bus.err, 0);
        check("t1_e3_busy", bus.busy, 1);
        tick();                                     // e4: IDLE -> DRIVE
        check("t1_e4_jk",   {bus.J, bus.K}, P0);
        tick();
        check("t1_e5_jk",   {bus.J, bus.K}, 0);
        check("t1_e5_q",    bus.Q, 0);
        tick();
        check("t1_e6_err",  bus.err, 0);
        check("t1_e6_busy", bus.busy, 0);
        check("t1_errcnt",  bus.err_cnt, 0);

        // Back-to-back 1,0,0,1 from Q=0
        do_reset();
        seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_jk = '{2'b00, P1, 2'b00, P0, 2'b00, 2'b00, 2'b00, P1, 2'b00, 2'b00};
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                bus.tgt_valid = 1'b1; bus.tgt_bit = seq[k];
                check($sformatf("t2_ready%0d", k), bus.tgt_ready, 1);
            end else begin
                bus.tgt_valid = 1'b0;
            end
            tick();
            check($sformatf("t2_jk%0d", k), {bus.J, bus.K}, exp_jk[k]);
            check($sformatf("t2_err%0d", k), bus.err, 0);
        end
        check("t2_q",      bus.Q, 1);
        check("t2_errcnt", bus.err_cnt, 0);
        check("t2_busy",   bus.busy, 0);

        // Stuck-at-0 flop: three mismatches, single-cycle pulses
        do_reset();
        q_stuck = 1'b1;
        pulses = 0; wide = 0; prev = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.tgt_valid = (k < 3); bus.tgt_bit = 1'b1;
            tick();
            if (bus.err) begin
                pulses++;
                if (prev) wide++;
            end
            prev = bus.err;
        end
        check("t3_pulses", pulses, 3);
        check("t3_wide",   wide, 0);
        check("t3_errcnt", bus.err_cnt, 3);
        check("t3_busy",   bus.busy, 0);

        // Continuous valid: ready tracks occupancy, counter saturates at 3
        do_reset();
        occ = 0; accepted = 0; saw_full = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bus.tgt_valid = (accepted < 12); bus.tgt_bit = 1'b1;
            acc = (bus.tgt_valid && bus.tgt_ready) ? 1 : 0;
            tick();
            popd = (bus.J || bus.K) ? 1 : 0;       // stuck Q=0, target 1: every DRIVE is nonzero
            occ = occ + acc - popd;
            accepted += acc;
            check($sformatf("t4_ready%0d", k), bus.tgt_ready, (occ < DEPTH) ? 1 : 0);
            if (!bus.tgt_ready) saw_full = 1'b1;
        end
        bus.tgt_valid = 1'b0;
        check("t4_accepted", accepted, 12);
        check("t4_sawfull",  saw_full, 1);
        check("t4_errcnt",   bus.err_cnt, 3);
        check("t4_busy",     bus.busy, 0);

        // Reset during DRIVE with three queued bits, push coincident with reset
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.tgt_valid = 1'b1; bus.tgt_bit = 1'b1;
            tick();
        end
        check("t5_pre_j",      bus.J, 1);
        check("t5_pre_errcnt", bus.err_cnt, 2);
        rst = 1'b1;
        tick();
        check("t5_jk",     {bus.J, bus.K}, 0);
        check("t5_busy",   bus.busy, 0);
        check("t5_ready",  bus.tgt_ready, 1);
        check("t5_errcnt", bus.err_cnt, 0);
        check("t5_err",    bus.err, 0);
        rst = 1'b0; bus.tgt_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t5_after_err%0d", k),  bus.err, 0);
            check($sformatf("t5_after_busy%0d", k), bus.busy, 0);
        end
        q_stuck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
